// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the sync generator and its pixel divider.
// Sync positions are derived so a changed porch width moves the pulse with it.
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int CLK_DIV   = 4;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Pixel-rate enable: one CLK-wide pulse every CLK_DIV system clocks.
// The pulse is decoded from the registered divider, so it is low throughout reset.
module pixel_tick_gen
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic CLK,
  input  logic RST,
  output logic ENClock
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] ONE     = DW'(1);

  logic [DW-1:0] div;

  always_ff @(posedge CLK) begin
    if (RST)                div <= '0;
    else if (div == DIV_MAX) div <= '0;
    else                    div <= div + ONE;
  end

  assign ENClock = (div == DIV_MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical raw counters with registered active-low syncs.
// Syncs are computed from the next counter values so they line up with ADDRH/ADDRV.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             HS,
  output logic             VS,
  output logic             ENClock,
  output logic [CNT_W-1:0] ADDRH,
  output logic [CNT_W-1:0] ADDRV
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK     (CLK),
    .RST     (RST),
    .ENClock (ENClock)
  );

  always_comb begin
    h_next = ADDRH;
    v_next = ADDRV;
    if (ENClock) begin
      if (ADDRH == H_LAST) begin
        h_next = '0;
        v_next = (ADDRV == V_LAST) ? '0 : ADDRV + ONE;
      end else begin
        h_next = ADDRH + ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ADDRH <= '0;
      ADDRV <= '0;
      HS    <= 1'b1;
      VS    <= 1'b1;
    end else begin
      ADDRH <= h_next;
      ADDRV <= v_next;
      HS    <= ~in_window(h_next, HS_LO, HS_HI);
      VS    <= ~in_window(v_next, VS_LO, VS_HI);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing over a few lines plus a shrunken instance for whole frames.
// Expected outputs come from the cycle count since reset release.
module tb_vga_sync_gen;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic       hs_b, vs_b, en_b;
  logic [9:0] h_b, v_b;
  logic       hs_s, vs_s, en_s;
  logic [9:0] h_s, v_s;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  vga_sync_gen u_big (
    .CLK(CLK), .RST(RST), .HS(hs_b), .VS(vs_b), .ENClock(en_b), .ADDRH(h_b), .ADDRV(v_b)
  );

  // 16 px x 10 lines, 2 clocks/pixel: HS low at px 10..12, VS low at lines 6..7
  vga_sync_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) u_small (
    .CLK(CLK), .RST(RST), .HS(hs_s), .VS(vs_s), .ENClock(en_s), .ADDRH(h_s), .ADDRV(v_s)
  );

  task automatic chk(input string tag, input int k, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, got, exp);
    end
  endtask

  task automatic chk_inst(input string name, input int k,
                          input logic en, input logic [9:0] h, input logic [9:0] v,
                          input logic hs, input logic vs,
                          input int cd, input int hv, input int hf, input int hsw, input int hb,
                          input int vv, input int vf, input int vsw, input int vb);
    int ht, vt, t, eh, ev;
    logic ee, ehs, evs;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    t   = k / cd;
    eh  = t % ht;
    ev  = (t / ht) % vt;
    ee  = ((k % cd) == cd - 1);
    ehs = !(eh >= hv + hf && eh < hv + hf + hsw);
    evs = !(ev >= vv + vf && ev < vv + vf + vsw);
    chk({name, "_en"}, k, {9'd0, en}, {9'd0, ee});
    chk({name, "_h"},  k, h, 10'(eh));
    chk({name, "_v"},  k, v, 10'(ev));
    chk({name, "_hs"}, k, {9'd0, hs}, {9'd0, ehs});
    chk({name, "_vs"}, k, {9'd0, vs}, {9'd0, evs});
  endtask

  task automatic check_all(input int k);
    chk_inst("big", k, en_b, h_b, v_b, hs_b, vs_b, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    chk_inst("small", k, en_s, h_s, v_s, hs_s, vs_s, 2, 8, 2, 3, 3, 4, 2, 2, 2);
  endtask

  initial begin
    int k;
    RST = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
      check_all(0);
    end
    RST = 1'b0;
    k = 0;
    check_all(k);
    // 7600 clocks = 1900 pixel ticks: past two line wraps, ends at ADDRH=300, ADDRV=2
    repeat (7600) begin
      @(posedge CLK); #1;
      k++;
      check_all(k);
    end
    chk("mid_h_pos", k, h_b, 10'd300);
    chk("mid_v_pos", k, v_b, 10'd2);

    RST = 1'b1;
    @(posedge CLK); #1;
    check_all(0);
    RST = 1'b0;
    k = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      k++;
      check_all(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
